// File: rtl/rename_allocator_pkg.sv
// Shared types and default sizing for the rename tag allocator.
// Also holds the width helpers used by the allocator and its picker.
package rename_allocator_pkg;

  localparam int DEF_TAG_COUNT   = 32;
  localparam int DEF_TAG_WIDTH   = 6;
  localparam int DEF_TAG_BASE    = 32;
  localparam int DEF_ALLOC_PORTS = 2;

  typedef logic [DEF_TAG_WIDTH-1:0] rename_tag_t;

  // Width needed to hold a pool index, never less than one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rename_allocator_free_tag_picker.sv
// Combinational finder for the k-th lowest free entry of the in-use vector.
// Port k always gets the (k+1)-th lowest free index, whichever ports request.
module free_tag_picker
  import rename_allocator_pkg::*;
#(
  parameter int TAG_COUNT   = DEF_TAG_COUNT,
  parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
  localparam int IDX_W      = idx_width(TAG_COUNT)
) (
  input  logic [TAG_COUNT-1:0] in_use,
  output logic [IDX_W-1:0]     pick [ALLOC_PORTS]
);

  // Walk the pool from the bottom, handing the n-th free index to port n.
  always_comb begin
    int seen;
    seen = 0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      pick[k] = '0;
    end
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (!in_use[i]) begin
        for (int k = 0; k < ALLOC_PORTS; k++) begin
          if (seen == k) begin
            pick[k] = IDX_W'(i);
          end
        end
        seen = seen + 1;
      end
    end
  end

endmodule

// File: rtl/rename_allocator.sv
// Rename tag pool: offers pre-selected free tags every cycle, grants them all-or-nothing,
// takes tags back from commit, recovers on flush and flags releases of idle tags.
module rename_allocator
  import rename_allocator_pkg::*;
#(
  parameter int TAG_COUNT   = DEF_TAG_COUNT,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int TAG_BASE    = DEF_TAG_BASE,
  parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
  localparam int CNT_W      = count_width(TAG_COUNT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [ALLOC_PORTS-1:0] rename,
  output logic [TAG_WIDTH-1:0]   tag [ALLOC_PORTS],
  output logic                   ready,
  input  logic [TAG_COUNT-1:0]   free,
  output logic [CNT_W-1:0]       free_count,
  output logic                   err_double_free
);

  localparam int IDX_W = idx_width(TAG_COUNT);
  localparam int EXT_W = CNT_W + 1;

  logic [TAG_COUNT-1:0] in_use;
  logic [TAG_COUNT-1:0] grant_mask;
  logic [TAG_COUNT-1:0] release_mask;
  logic [IDX_W-1:0]     pick [ALLOC_PORTS];
  logic [EXT_W-1:0]     grant_cnt;
  logic [EXT_W-1:0]     release_cnt;
  logic                 double_free;

  free_tag_picker #(
    .TAG_COUNT   (TAG_COUNT),
    .ALLOC_PORTS (ALLOC_PORTS)
  ) u_picker (
    .in_use (in_use),
    .pick   (pick)
  );

  // Whole dispatch group or nothing; flush blocks the group so the pool can rebuild.
  assign ready = (free_count >= CNT_W'(ALLOC_PORTS)) && !flush;

  always_comb begin
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      tag[k] = TAG_WIDTH'(TAG_BASE + int'(pick[k]));
    end
  end

  always_comb begin
    grant_mask = '0;
    grant_cnt  = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      if (rename[k] && ready) begin
        grant_mask[pick[k]] = 1'b1;
        grant_cnt           = grant_cnt + EXT_W'(1);
      end
    end
  end

  // Only tags actually held count as returns; the rest are reported, not applied.
  assign release_mask = free & in_use;
  assign double_free  = |(free & ~in_use);

  always_comb begin
    release_cnt = '0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      release_cnt = release_cnt + EXT_W'(release_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      in_use          <= '0;
      free_count      <= CNT_W'(TAG_COUNT);
      err_double_free <= 1'b0;
    end else begin
      in_use          <= (in_use & ~release_mask) | grant_mask;
      free_count      <= CNT_W'(EXT_W'(free_count) + release_cnt - grant_cnt);
      err_double_free <= double_free;
    end
  end

endmodule

// File: tb/tb_rename_allocator.sv
// Directed and random bench for rename_allocator with a scoreboard of expected outputs
// fed by a behavioural pool model and by fixed values at the key scenario points.
module tb_rename_allocator;
  import rename_allocator_pkg::*;

  localparam int N    = 32;
  localparam int BASE = 32;
  localparam int P    = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [P-1:0] rename;
  logic [N-1:0] free;
  rename_tag_t  tag [P];
  logic         ready;
  logic [5:0]   free_count;
  logic         err_double_free;

  int vectors     = 0;
  int miscompares = 0;

  bit m_used [N];
  int m_count;
  bit m_err;

  typedef struct {
    string name;
    int    t0;
    int    t1;
    bit    v0;
    bit    v1;
    bit    rdy;
    int    cnt;
    bit    err;
  } exp_t;

  exp_t sb[$];

  rename_allocator #(
    .TAG_COUNT   (N),
    .TAG_WIDTH   (6),
    .TAG_BASE    (BASE),
    .ALLOC_PORTS (P)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .rename          (rename),
    .tag             (tag),
    .ready           (ready),
    .free            (free),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  function automatic int nth_free(int n);
    int seen = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_used[i]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic void push_model(string name);
    exp_t e;
    int c0 = nth_free(0);
    int c1 = nth_free(1);
    e.name = name;
    e.v0   = (c0 >= 0);
    e.t0   = BASE + c0;
    e.v1   = (c1 >= 0);
    e.t1   = BASE + c1;
    e.rdy  = (m_count >= P) && !flush;
    e.cnt  = m_count;
    e.err  = m_err;
    sb.push_back(e);
  endfunction

  function automatic void push_const(string name, int t0, int t1, bit v1, bit rdy, int cnt, bit err);
    exp_t e;
    e.name = name;
    e.t0   = t0;
    e.v0   = 1'b1;
    e.t1   = t1;
    e.v1   = v1;
    e.rdy  = rdy;
    e.cnt  = cnt;
    e.err  = err;
    sb.push_back(e);
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_update();
    int c [P];
    bit rdy;
    bit dbl;
    for (int k = 0; k < P; k++) c[k] = nth_free(k);
    rdy = (m_count >= P) && !flush;
    if (flush) begin
      for (int i = 0; i < N; i++) m_used[i] = 1'b0;
      m_count = N;
      m_err   = 1'b0;
    end else begin
      dbl = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (free[i]) begin
          if (m_used[i]) begin
            m_used[i] = 1'b0;
            m_count++;
          end else begin
            dbl = 1'b1;
          end
        end
      end
      for (int k = 0; k < P; k++) begin
        if (rename[k] && rdy) begin
          m_used[c[k]] = 1'b1;
          m_count--;
        end
      end
      m_err = dbl;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    if (e.v0) begin
      vectors++;
      assert ({26'b0, tag[0]} === 32'(e.t0)) else begin
        miscompares++;
        $error("[TB] FAIL %s tag0 got %0d want %0d", e.name, tag[0], e.t0);
      end
    end
    if (e.v1) begin
      vectors++;
      assert ({26'b0, tag[1]} === 32'(e.t1)) else begin
        miscompares++;
        $error("[TB] FAIL %s tag1 got %0d want %0d", e.name, tag[1], e.t1);
      end
    end
    vectors++;
    assert (ready === e.rdy) else begin
      miscompares++;
      $error("[TB] FAIL %s ready got %b want %b", e.name, ready, e.rdy);
    end
    vectors++;
    assert ({26'b0, free_count} === 32'(e.cnt)) else begin
      miscompares++;
      $error("[TB] FAIL %s free_count got %0d want %0d", e.name, free_count, e.cnt);
    end
    vectors++;
    assert (err_double_free === e.err) else begin
      miscompares++;
      $error("[TB] FAIL %s err_double_free got %b want %b", e.name, err_double_free, e.err);
    end
  endtask

  // Drive one cycle of stimulus, check the pre-edge outputs, then clock it in.
  task automatic applyStimulus(string name, logic [P-1:0] r, logic [N-1:0] f, logic fl);
    rename = r;
    free   = f;
    flush  = fl;
    #1;
    push_model(name);
    checkOutput();
    model_update();
    @(posedge clk);
    #1;
    rename = '0;
    free   = '0;
    flush  = 1'b0;
    #1;
  endtask

  task automatic check_const(string name, int t0, int t1, bit v1, bit rdy, int cnt, bit err);
    push_const(name, t0, t1, v1, rdy, cnt, err);
    checkOutput();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    rename = '0;
    free   = '0;
    flush  = 1'b0;
    for (int i = 0; i < N; i++) m_used[i] = 1'b0;
    m_count = N;
    m_err   = 1'b0;
    #1;
  endtask

  initial begin
    logic [N-1:0] f;
    reset  = 1'b1;
    flush  = 1'b0;
    rename = '0;
    free   = '0;

    do_reset();
    check_const("reset_idle", 32, 33, 1, 1, 32, 0);

    applyStimulus("grant_both", 2'b11, '0, 1'b0);
    check_const("after_grant_both", 34, 35, 1, 1, 30, 0);

    do_reset();
    applyStimulus("grant_port1", 2'b10, '0, 1'b0);
    check_const("after_grant_port1", 32, 34, 1, 1, 31, 0);

    for (int s = 0; s < 15; s++) applyStimulus("fill", 2'b11, '0, 1'b0);
    check_const("one_left", 63, 0, 0, 0, 1, 0);
    for (int s = 0; s < 3; s++) applyStimulus("hold_not_ready", 2'b11, '0, 1'b0);
    check_const("one_left_held", 63, 0, 0, 0, 1, 0);

    do_reset();
    applyStimulus("pre_a", 2'b11, '0, 1'b0);
    applyStimulus("pre_b", 2'b11, '0, 1'b0);
    check_const("before_free_grant", 36, 37, 1, 1, 28, 0);
    applyStimulus("free_and_grant", 2'b11, N'(1) << 2, 1'b0);
    check_const("freed_tag_offered", 34, 38, 1, 1, 27, 0);

    do_reset();
    applyStimulus("double_free", 2'b00, N'(1) << 5, 1'b0);
    check_const("err_pulse", 32, 33, 1, 1, 32, 1);
    applyStimulus("err_clears", 2'b00, '0, 1'b0);
    check_const("err_gone", 32, 33, 1, 1, 32, 0);

    do_reset();
    for (int s = 0; s < 10; s++) applyStimulus("fill20", 2'b11, '0, 1'b0);
    check_const("twenty_used", 52, 53, 1, 1, 12, 0);
    applyStimulus("flush", 2'b11, N'(1), 1'b1);
    check_const("after_flush", 32, 33, 1, 1, 32, 0);

    for (int s = 0; s < 3; s++) applyStimulus("pre_reset", 2'b11, '0, 1'b0);
    rename = 2'b11;
    free   = N'(1);
    do_reset();
    check_const("mid_reset", 32, 33, 1, 1, 32, 0);

    for (int s = 0; s < 60; s++) begin
      f = '0;
      if ($urandom_range(0, 1) == 0) f[$urandom_range(0, N-1)] = 1'b1;
      applyStimulus("random", 2'($urandom_range(0, 3)), f, ($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
